rs232_avalon_slave: RTL



---
 rtl/rs232_avalon_slave.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/rs232_avalon_slave.sv
// Avalon-MM UART slave: RX holding register, TX shifter and STATUS flags behind a
// fixed two-cycle bus handshake. Single clock, synchronous active-high reset.
module rs232_avalon_slave #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("CLK_HZ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic        ack_q;
  logic [31:0] readdata_q;
  logic [31:0] readdata_d;

  rx_state_t   rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_byte_q;
  logic        rx_valid_q;
  logic        rx_overrun_q;
  logic        frame_err_q;
  logic        rxd_meta_q;
  logic        rxd_sync_q;
  logic        rxd_prev_q;

  tx_state_t   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q;
  logic        tx_drop_q;

  logic req, done, is_rx, is_tx, is_st;
  logic rx_pop, st_clr, tx_wr, tx_ready;
  logic wdata_unused;

  assign wdata_unused = ^avs_writedata[31:8];

  assign req   = avs_read | avs_write;
  assign is_rx = (avs_address == 5'd0);
  assign is_tx = (avs_address == 5'd4);
  assign is_st = (avs_address == 5'd8);
  assign done  = req & ack_q;

  // Side effects fire only in the completion cycle; read wins over write.
  assign rx_pop = done & avs_read & is_rx;
  assign st_clr = done & avs_read & is_st;
  assign tx_wr  = done & ~avs_read & avs_write & is_tx;

  assign tx_ready        = (tx_state_q == TX_IDLE);
  assign avs_waitrequest = req & ~ack_q;
  assign avs_readdata    = readdata_q;
  assign uart_txd        = txd_q;

  always_comb begin
    readdata_d = '0;
    if (is_rx) begin
      readdata_d[7:0] = rx_byte_q;
    end else if (is_st) begin
      readdata_d[7:0] = {rx_valid_q, tx_ready, 2'b00, rx_overrun_q, frame_err_q, tx_drop_q, 1'b0};
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      ack_q      <= 1'b0;
      readdata_q <= '0;
    end else if (req && !ack_q) begin
      ack_q      <= 1'b1;
      readdata_q <= readdata_d;
    end else begin
      ack_q <= 1'b0;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // Clears first so that a set later in this block takes precedence.
      if (rx_pop) rx_valid_q <= 1'b0;
      if (st_clr) begin
        rx_overrun_q <= 1'b0;
        frame_err_q  <= 1'b0;
      end
      case (rx_state_q)
        RX_IDLE: begin
          if (rxd_prev_q && !rxd_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_BIT) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rxd_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rxd_sync_q) begin
              rx_byte_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !rx_pop) rx_overrun_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= RX_BREAK;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_BREAK: begin
          if (rxd_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_drop_q  <= 1'b0;
    end else begin
      if (st_clr) tx_drop_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_shift_q <= avs_writedata[7:0];
            tx_cnt_q   <= '0;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
      // A write that finds the shifter busy is lost but remembered.
      if (tx_wr && tx_state_q != TX_IDLE) tx_drop_q <= 1'b1;
    end
  end

endmodule
